// File: rtl/instr_encoder.sv
// Encodes symbolic ADD/SUB/LD/SD/ADDI requests into 32-bit instruction words
// and buffers them in a DEPTH-entry FIFO. The FIFO head goes to the decoder
// through a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (req_ready = !full)
//   req_op/rd/rs1/rs2/imm   symbolic request fields
//   instr_valid/ready head handshake (instr_valid = !empty)
//   instruction       head word, 0 when empty
//   err_illegal       one-cycle pulse after an illegal op is accepted
//   fill_count        entries held, 0..DEPTH
//   instr_parity      only with INSTR_ENC_PARITY_EN: even parity of head, 0 when empty
module instr_encoder #(
   parameter int SIZE  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [2:0]               req_op,
   input  logic [4:0]               req_rd,
   input  logic [4:0]               req_rs1,
   input  logic [4:0]               req_rs2,
   input  logic [11:0]              req_imm,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [SIZE-1:0]          instruction,
   output logic                     err_illegal,
`ifdef INSTR_ENC_PARITY_EN
   output logic                     instr_parity,
`endif
   output logic [$clog2(DEPTH):0]   fill_count
);

   localparam int AW = $clog2(DEPTH);
`ifdef INSTR_ENC_PARITY_EN
   localparam int FW = SIZE + 1;
`else
   localparam int FW = SIZE;
`endif
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [FW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            err_q, err_d;

   logic            op_add, op_sub, op_ld, op_sd, op_addi;
   logic [SIZE-1:0] enc_word;
   logic            enc_legal;
   logic [FW-1:0]   enc_entry;
   logic            push, wr_en, pop;

   assign op_add  = (req_op == 3'b000);
   assign op_sub  = (req_op == 3'b001);
   assign op_ld   = (req_op == 3'b010);
   assign op_sd   = (req_op == 3'b011);
   assign op_addi = (req_op == 3'b100);

   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      unique case (1'b1)
         op_add:  enc_word = {7'b0000000, req_rs2, req_rs1,
                              3'b000, req_rd, 7'b0110011};
         op_sub:  enc_word = {7'b0100000, req_rs2, req_rs1,
                              3'b000, req_rd, 7'b0110011};
         op_ld:   enc_word = {req_imm, req_rs1,
                              3'b011, req_rd, 7'b0000011};
         op_sd:   enc_word = {req_imm[11:5], req_rs2, req_rs1,
                              3'b011, req_imm[4:0], 7'b0100011};
         op_addi: enc_word = {req_imm, req_rs1,
                              3'b000, req_rd, 7'b0010011};
         default: enc_legal = 1'b0;
      endcase
   end

`ifdef INSTR_ENC_PARITY_EN
   assign enc_entry = {^enc_word, enc_word};
`else
   assign enc_entry = enc_word;
`endif

   // Full blocks the request even when a pop happens the same cycle.
   assign req_ready   = (count_q != FULL_CNT);
   assign instr_valid = (count_q != '0);
   assign push        = req_valid && req_ready;
   assign wr_en       = push && enc_legal;
   assign pop         = instr_valid && instr_ready;

   assign instruction = instr_valid ? mem_q[rd_ptr_q][SIZE-1:0] : '0;
`ifdef INSTR_ENC_PARITY_EN
   assign instr_parity = instr_valid ? mem_q[rd_ptr_q][SIZE] : 1'b0;
`endif
   assign err_illegal = err_q;
   assign fill_count  = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = push && !enc_legal;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (!wr_en && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= enc_entry;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus random traffic
// compared against a queue-based reference model.
module tb_instr_encoder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [4:0]  req_rd, req_rs1, req_rs2;
   logic [11:0] req_imm;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic        err_illegal;
   logic [2:0]  fill_count;
`ifdef INSTR_ENC_PARITY_EN
   logic        instr_parity;
`endif

   always #5 clk = ~clk;

   instr_encoder #(.SIZE(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
      .req_rs2(req_rs2), .req_imm(req_imm),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .err_illegal(err_illegal),
`ifdef INSTR_ENC_PARITY_EN
      .instr_parity(instr_parity),
`endif
      .fill_count(fill_count)
   );

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] q[$];
   logic        err_exp = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      n_chk++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask

   // Field placement from the ISA layout, built with shifts.
   function automatic logic [31:0] ref_enc(input logic [2:0] op,
      input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [11:0] imm);
      logic [31:0] r1, r2, d, im;
      r1 = 32'(rs1) << 15;
      r2 = 32'(rs2) << 20;
      d  = 32'(rd) << 7;
      im = 32'(imm);
      case (op)
         3'd0: return r2 | r1 | d | 32'h33;
         3'd1: return (32'h20 << 25) | r2 | r1 | d | 32'h33;
         3'd2: return (im << 20) | r1 | (32'd3 << 12) | d | 32'h03;
         3'd3: return ((im >> 5) << 25) | r2 | r1 | (32'd3 << 12)
                      | ((im & 32'h1F) << 7) | 32'h23;
         default: return (im << 20) | r1 | d | 32'h13;
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      logic [31:0] head;
      head = (q.size() > 0) ? q[0] : 32'h0;
      chk({tag, ".valid"}, 32'(instr_valid), 32'(q.size() > 0));
      chk({tag, ".instr"}, instruction, head);
      chk({tag, ".count"}, 32'(fill_count), 32'(q.size()));
      chk({tag, ".ready"}, 32'(req_ready), 32'(q.size() < DEPTH));
      chk({tag, ".err"}, 32'(err_illegal), 32'(err_exp));
`ifdef INSTR_ENC_PARITY_EN
      chk({tag, ".par"}, 32'(instr_parity), 32'(^head));
`endif
   endtask

   task automatic step(input string tag, input logic v,
      input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [11:0] imm, input logic rdy);
      bit push, pop;
      req_valid = v; req_op = op; req_rd = rd;
      req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
      instr_ready = rdy;
      push = v && (q.size() < DEPTH);
      pop  = rdy && (q.size() > 0);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (push && op < 3'd5) q.push_back(ref_enc(op, rd, rs1, rs2, imm));
      err_exp = push && (op >= 3'd5);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag, input logic rdy);
      step(tag, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 12'd0, rdy);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_rd = 5'd0;
      req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 12'd0; instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      rst_n = 1'b1;

      // ADD then SUB, each visible one cycle after push
      step("add", 1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 12'h5A5, 1'b1);
      chk("add.lit", instruction, 32'h002081B3);
      step("sub", 1'b1, 3'd1, 5'd3, 5'd1, 5'd2, 12'h000, 1'b1);
      chk("sub.lit", instruction, 32'h402081B3);
      step("ld", 1'b1, 3'd2, 5'd5, 5'd2, 5'd17, 12'd8, 1'b1);
      chk("ld.lit", instruction, 32'h00813283);
      step("sd", 1'b1, 3'd3, 5'd31, 5'd2, 5'd5, 12'd16, 1'b1);
      chk("sd.lit", instruction, 32'h00513823);
      step("addi", 1'b1, 3'd4, 5'd1, 5'd0, 5'd9, 12'hFFF, 1'b1);
      chk("addi.lit", instruction, 32'hFFF00093);
      idle("drain0", 1'b1);

      // fill to full with consumer stalled, 5th push ignored
      for (int i = 0; i < 5; i++)
         step("fill", 1'b1, 3'd0, 5'(i + 1), 5'd1, 5'd2, 12'd0, 1'b0);
      chk("full.ready", 32'(req_ready), 32'd0);
      chk("full.count", 32'(fill_count), 32'd4);
      // full with pop: push still refused
      step("fullpop", 1'b1, 3'd1, 5'd9, 5'd9, 5'd9, 12'd0, 1'b1);
      for (int i = 0; i < 4; i++) idle("drain", 1'b1);
      chk("empty.valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 3; i++)
         step("wrap", 1'b1, 3'd4, 5'(i), 5'(i + 4), 5'd0, 12'(i * 7), 1'b0);
      for (int i = 0; i < 3; i++) idle("wdrain", 1'b1);

      // illegal op at count=2, then push+pop at count=2
      step("il0", 1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 12'd0, 1'b0);
      step("il1", 1'b1, 3'd2, 5'd4, 5'd5, 5'd6, 12'd44, 1'b0);
      step("illegal", 1'b1, 3'd7, 5'd7, 5'd7, 5'd7, 12'd7, 1'b0);
      chk("ill.err", 32'(err_illegal), 32'd1);
      chk("ill.count", 32'(fill_count), 32'd2);
      idle("ill.after", 1'b0);
      chk("ill.err0", 32'(err_illegal), 32'd0);
      step("pushpop", 1'b1, 3'd3, 5'd0, 5'd8, 5'd9, 12'h123, 1'b1);
      chk("pp.count", 32'(fill_count), 32'd2);

      // asynchronous reset while holding 3
      step("pre3", 1'b1, 3'd1, 5'd10, 5'd11, 5'd12, 12'd0, 1'b0);
      chk("pre3.count", 32'(fill_count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      err_exp = 1'b0;
      check_outputs("midrst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_outputs("postrst");

      // random traffic
      for (int i = 0; i < 400; i++)
         step("rnd", 1'($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
              5'($urandom), 12'($urandom), 1'($urandom_range(0, 2) == 0));
      for (int i = 0; i < 6; i++) idle("fin", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
